// File: rtl/agnus_dma_arbiter.sv
// agnus_dma_arbiter
// Chip-bus DMA slot arbiter. One slot is one CCK (two clk7_en ticks).
// Odd CCKs carry fixed slots (refresh, disk, audio, sprite). A fixed slot
// that is not used, and every even CCK, is a free slot. Free slots go to
// bitplane > copper > blitter > CPU. A starvation counter lets the CPU
// win over the blitter after CPU_STARVE_MAX lost free slots.
// Build option: define AGNUS_BLTPRI_EN to honour bltpri. When bltpri is high
// the starvation override is disabled. Without the macro, bltpri is ignored.
// Slot map note: audio channel 3 owns CCK 0x15. Sprite DMA therefore uses
// the odd CCKs 0x17..0x33.

module agnus_dma_arbiter #(
    parameter int CPU_STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk7_en,
    input  logic [8:0] hpos,
    input  logic       dmaen,
    input  logic       req_dsk,
    input  logic [3:0] req_aud,
    input  logic       req_spr,
    input  logic       req_bpl,
    input  logic       req_cop,
    input  logic       req_blt,
    input  logic       req_cpu,
    input  logic       bltpri,
    output logic [7:0] gnt,
    output logic [2:0] owner,
    output logic [1:0] aud_chan,
    output logic       bus_busy
);

    localparam int SW = (CPU_STARVE_MAX < 1) ? 1 : $clog2(CPU_STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE_MAX);

    localparam logic [2:0] OWN_REF  = 3'd0;
    localparam logic [2:0] OWN_DSK  = 3'd1;
    localparam logic [2:0] OWN_AUD  = 3'd2;
    localparam logic [2:0] OWN_SPR  = 3'd3;
    localparam logic [2:0] OWN_BPL  = 3'd4;
    localparam logic [2:0] OWN_COP  = 3'd5;
    localparam logic [2:0] OWN_BLT  = 3'd6;
    localparam logic [2:0] OWN_IDLE = 3'd7;

    logic [7:0]    cck;
    logic [7:0]    aud_off;
    logic [1:0]    aud_idx;
    logic          decide;
    logic          slot_ref;
    logic          slot_dsk;
    logic          slot_aud;
    logic          slot_spr;
    logic          blt_nasty;
    logic          cpu_override;
    logic          free_slot;
    logic [7:0]    nxt_gnt;
    logic [2:0]    nxt_owner;
    logic [1:0]    nxt_aud;
    logic [SW-1:0] starve;
    logic [SW-1:0] nxt_starve;

    assign cck     = hpos[8:1];
    assign decide  = clk7_en & ~hpos[0];
    assign aud_off = cck - 8'h0F;
    assign aud_idx = aud_off[2:1];

    assign slot_ref = cck[0] && (cck <= 8'h07);
    assign slot_dsk = cck[0] && (cck >= 8'h09) && (cck <= 8'h0D);
    assign slot_aud = cck[0] && (cck >= 8'h0F) && (cck <= 8'h15);
    assign slot_spr = cck[0] && (cck >= 8'h17) && (cck <= 8'h33);

`ifdef AGNUS_BLTPRI_EN
    assign blt_nasty = bltpri;
`else
    // bltpri is deliberately ignored in this build.
    assign blt_nasty = bltpri & 1'b0;
`endif

    assign cpu_override = (starve == STARVE_MAX) && !blt_nasty;

    // Pick the owner of the slot starting at this decision tick.
    always_comb begin
        nxt_gnt   = 8'h00;
        nxt_owner = OWN_IDLE;
        nxt_aud   = aud_chan;
        free_slot = 1'b0;
        if (slot_ref) begin
            nxt_gnt[OWN_REF] = 1'b1;
            nxt_owner        = OWN_REF;
        end else if (slot_dsk && dmaen && req_dsk) begin
            nxt_gnt[OWN_DSK] = 1'b1;
            nxt_owner        = OWN_DSK;
        end else if (slot_aud && dmaen && req_aud[aud_idx]) begin
            nxt_gnt[OWN_AUD] = 1'b1;
            nxt_owner        = OWN_AUD;
            nxt_aud          = aud_idx;
        end else if (slot_spr && dmaen && req_spr) begin
            nxt_gnt[OWN_SPR] = 1'b1;
            nxt_owner        = OWN_SPR;
        end else begin
            free_slot = 1'b1;
            if (dmaen && req_bpl) begin
                nxt_gnt[OWN_BPL] = 1'b1;
                nxt_owner        = OWN_BPL;
            end else if (dmaen && req_cop && !cck[0]) begin
                nxt_gnt[OWN_COP] = 1'b1;
                nxt_owner        = OWN_COP;
            end else if (dmaen && req_blt && !(req_cpu && cpu_override)) begin
                nxt_gnt[OWN_BLT] = 1'b1;
                nxt_owner        = OWN_BLT;
            end else if (req_cpu) begin
                nxt_gnt[7] = 1'b1;
                nxt_owner  = OWN_IDLE;
            end
        end
    end

    // Count free slots the CPU lost to the blitter; saturate, never wrap.
    always_comb begin
        nxt_starve = starve;
        if (!req_cpu || (free_slot && nxt_gnt[7])) begin
            nxt_starve = '0;
        end else if (free_slot && nxt_gnt[OWN_BLT] && (starve != STARVE_MAX)) begin
            nxt_starve = starve + SW'(1);
        end
    end

    // Register the grant at each decision tick; hold it through the second half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt      <= 8'h00;
            owner    <= OWN_IDLE;
            aud_chan <= 2'd0;
            starve   <= '0;
        end else if (decide) begin
            gnt      <= nxt_gnt;
            owner    <= nxt_owner;
            aud_chan <= nxt_aud;
            starve   <= nxt_starve;
        end
    end

    assign bus_busy = |gnt[6:0];

endmodule
